// File: rtl/rom_arbiter_pkg.sv
// Shared encodings for the ROM arbiter slice.
//   OWNER_*  : who owns the ROM word returning in the next cycle
//   PRIO_*   : PRIORITY_MODE parameter encodings
package rom_arbiter_pkg;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  localparam int unsigned PRIO_RR      = 0;
  localparam int unsigned PRIO_FIXED_A = 1;

endpackage

// File: rtl/rom_arb_rr2.sv
// Two-way grant logic with a last-grant register.
//   CLK, RSTb    : clock, asynchronous active-low reset
//   req_a, req_b : requests from port A and port B
//   fixed_prio   : 1 = A always wins contention, 0 = round-robin
//   gnt          : one-hot grant, bit 0 = A, bit 1 = B (combinational)
module rom_arb_rr2 (
  input  logic       CLK,
  input  logic       RSTb,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       fixed_prio,
  output logic [1:0] gnt
);

  // Set when B received the most recent grant; resets to B so A wins first contention.
  logic last_b_q, last_b_d;

  always_comb begin
    gnt = 2'b00;
    case ({req_b, req_a})
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (fixed_prio || last_b_q) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_b_d = last_b_q;
    if (gnt[0]) begin
      last_b_d = 1'b0;
    end else if (gnt[1]) begin
      last_b_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two requesters onto one synchronous-read ROM (1-cycle read latency).
//   CLK, RSTb                  : clock, asynchronous active-low reset
//   A_REQ/A_ADDR               : port A request and word address
//   A_GNT                      : port A accepted this cycle (combinational)
//   A_RVALID/A_RDATA           : port A read data, valid one cycle after grant;
//                                A_RDATA holds the last delivered word otherwise
//   B_*                        : same for port B
//   ROM_ADDRESS / ROM_DATA     : to ROM address input / from ROM data output
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned BITS          = 16,
  parameter int unsigned ADDRESS_BITS  = 8,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    A_REQ,
  input  logic [ADDRESS_BITS-1:0] A_ADDR,
  output logic                    A_GNT,
  output logic                    A_RVALID,
  output logic [BITS-1:0]         A_RDATA,
  input  logic                    B_REQ,
  input  logic [ADDRESS_BITS-1:0] B_ADDR,
  output logic                    B_GNT,
  output logic                    B_RVALID,
  output logic [BITS-1:0]         B_RDATA,
  output logic [ADDRESS_BITS-1:0] ROM_ADDRESS,
  input  logic [BITS-1:0]         ROM_DATA
);

  localparam logic FixedPrio = (PRIORITY_MODE == PRIO_FIXED_A);

  logic [1:0]              gnt;
  logic [ADDRESS_BITS-1:0] rom_addr_q;
  logic [1:0]              owner_q, owner_d;
  logic [BITS-1:0]         a_hold_q, b_hold_q;

  rom_arb_rr2 u_rr2 (
    .CLK        (CLK),
    .RSTb       (RSTb),
    .req_a      (A_REQ),
    .req_b      (B_REQ),
    .fixed_prio (FixedPrio),
    .gnt        (gnt)
  );

  assign A_GNT = gnt[0];
  assign B_GNT = gnt[1];

  // Idle cycles replay the last granted address so the ROM input never toggles.
  always_comb begin
    ROM_ADDRESS = rom_addr_q;
    owner_d     = OWNER_NONE;
    if (gnt[0]) begin
      ROM_ADDRESS = A_ADDR;
      owner_d     = OWNER_A;
    end else if (gnt[1]) begin
      ROM_ADDRESS = B_ADDR;
      owner_d     = OWNER_B;
    end
  end

  assign A_RVALID = (owner_q == OWNER_A);
  assign B_RVALID = (owner_q == OWNER_B);
  assign A_RDATA  = A_RVALID ? ROM_DATA : a_hold_q;
  assign B_RDATA  = B_RVALID ? ROM_DATA : b_hold_q;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      rom_addr_q <= '0;
      owner_q    <= OWNER_NONE;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
    end else begin
      rom_addr_q <= ROM_ADDRESS;
      owner_q    <= owner_d;
      if (A_RVALID) a_hold_q <= ROM_DATA;
      if (B_RVALID) b_hold_q <= ROM_DATA;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench: a round-robin instance (r_*) and a fixed-priority instance (f_*)
// share request stimulus; each has its own registered ROM model mem[i] = {i, ~i}.
module tb_rom_arbiter;

  logic       CLK = 1'b0;
  logic       RSTb = 1'b0;
  logic       A_REQ = 1'b0, B_REQ = 1'b0;
  logic [7:0] A_ADDR = '0, B_ADDR = '0;

  logic        r_a_gnt, r_a_rvalid, r_b_gnt, r_b_rvalid;
  logic [15:0] r_a_rdata, r_b_rdata, r_rom_data;
  logic [7:0]  r_rom_addr;
  logic        f_a_gnt, f_a_rvalid, f_b_gnt, f_b_rvalid;
  logic [15:0] f_a_rdata, f_b_rdata, f_rom_data;
  logic [7:0]  f_rom_addr;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    return {a, ~a};
  endfunction

  always @(posedge CLK) r_rom_data <= rom_word(r_rom_addr);
  always @(posedge CLK) f_rom_data <= rom_word(f_rom_addr);

  rom_arbiter #(.BITS(16), .ADDRESS_BITS(8), .PRIORITY_MODE(0)) dut_rr (
    .CLK (CLK), .RSTb (RSTb),
    .A_REQ (A_REQ), .A_ADDR (A_ADDR), .A_GNT (r_a_gnt), .A_RVALID (r_a_rvalid),
    .A_RDATA (r_a_rdata),
    .B_REQ (B_REQ), .B_ADDR (B_ADDR), .B_GNT (r_b_gnt), .B_RVALID (r_b_rvalid),
    .B_RDATA (r_b_rdata),
    .ROM_ADDRESS (r_rom_addr), .ROM_DATA (r_rom_data)
  );

  rom_arbiter #(.BITS(16), .ADDRESS_BITS(8), .PRIORITY_MODE(1)) dut_fx (
    .CLK (CLK), .RSTb (RSTb),
    .A_REQ (A_REQ), .A_ADDR (A_ADDR), .A_GNT (f_a_gnt), .A_RVALID (f_a_rvalid),
    .A_RDATA (f_a_rdata),
    .B_REQ (B_REQ), .B_ADDR (B_ADDR), .B_GNT (f_b_gnt), .B_RVALID (f_b_rvalid),
    .B_RDATA (f_b_rdata),
    .ROM_ADDRESS (f_rom_addr), .ROM_DATA (f_rom_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reset pulse inside a cycle, away from both edges, requests idle.
  task automatic pulse_reset();
    tick();
    A_REQ = 1'b0;
    B_REQ = 1'b0;
    RSTb  = 1'b0;
    #2;
    RSTb  = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_a_gnt", r_a_gnt, 0);
    check("rst_b_gnt", r_b_gnt, 0);
    check("rst_a_rvalid", r_a_rvalid, 0);
    check("rst_b_rvalid", r_b_rvalid, 0);
    check("rst_a_rdata", r_a_rdata, 0);
    check("rst_b_rdata", r_b_rdata, 0);
    check("rst_rom_addr", r_rom_addr, 0);
    #1 RSTb = 1'b1;

    // A-only read
    tick();
    A_REQ = 1'b1; A_ADDR = 8'h03;
    #1;
    check("aonly_a_gnt", r_a_gnt, 1);
    check("aonly_b_gnt", r_b_gnt, 0);
    check("aonly_rom_addr", r_rom_addr, 8'h03);
    tick();
    A_REQ = 1'b0;
    #1;
    check("aonly_a_rvalid", r_a_rvalid, 1);
    check("aonly_a_rdata", r_a_rdata, 16'h03FC);
    check("aonly_b_rvalid", r_b_rvalid, 0);

    // Contention: round-robin alternates A,B,A,B; fixed always grants A
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      A_REQ = 1'b1; A_ADDR = 8'h10;
      B_REQ = 1'b1; B_ADDR = 8'h20;
      #1;
      check("rr_a_gnt", r_a_gnt, (i % 2 == 0));
      check("rr_b_gnt", r_b_gnt, (i % 2 == 1));
      check("fx_a_gnt", f_a_gnt, 1);
      check("fx_b_gnt", f_b_gnt, 0);
      if (i > 0) begin
        check("rr_a_rvalid", r_a_rvalid, (i % 2 == 1));
        check("rr_b_rvalid", r_b_rvalid, (i % 2 == 0));
        if (i % 2 == 1) check("rr_a_rdata", r_a_rdata, 16'h10EF);
        else            check("rr_b_rdata", r_b_rdata, 16'h20DF);
        check("fx_a_rvalid", f_a_rvalid, 1);
        check("fx_a_rdata", f_a_rdata, 16'h10EF);
        check("fx_b_rvalid", f_b_rvalid, 0);
      end
    end
    // Drop A: fixed instance grants B the same cycle
    tick();
    A_REQ = 1'b0;
    #1;
    check("fx_drop_b_gnt", f_b_gnt, 1);
    check("fx_drop_a_gnt", f_a_gnt, 0);
    check("rr_last_b_rvalid", r_b_rvalid, 1);
    check("rr_last_b_rdata", r_b_rdata, 16'h20DF);
    tick();
    B_REQ = 1'b0;
    #1;
    check("fx_drop_b_rvalid", f_b_rvalid, 1);
    check("fx_drop_b_rdata", f_b_rdata, 16'h20DF);
    check("fx_drop_a_rvalid", f_a_rvalid, 0);

    // Data hold: A reads 05, then B reads 06 twice while A idles
    tick();
    A_REQ = 1'b1; A_ADDR = 8'h05;
    #1;
    check("hold_a_gnt", r_a_gnt, 1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      A_REQ = 1'b0;
      B_REQ = (c == 1 || c == 3);
      B_ADDR = 8'h06;
      #1;
      check("hold_a_rvalid", r_a_rvalid, (c == 1));
      check("hold_a_rdata", r_a_rdata, 16'h05FA);
      check("hold_b_rvalid", r_b_rvalid, (c == 2 || c == 4));
      if (c >= 2) check("hold_b_rdata", r_b_rdata, 16'h06F9);
    end
    B_REQ = 1'b0;

    // Reset mid-operation: A granted, then B granted at 40 with reset inside that cycle
    tick();
    A_REQ = 1'b1; A_ADDR = 8'h11;
    tick();
    A_REQ = 1'b0;
    B_REQ = 1'b1; B_ADDR = 8'h40;
    #1;
    check("mrst_b_gnt", r_b_gnt, 1);
    check("mrst_rom_addr", r_rom_addr, 8'h40);
    B_REQ = 1'b0;
    RSTb  = 1'b0;
    #1;
    check("mrst_in_a_rvalid", r_a_rvalid, 0);
    check("mrst_in_a_rdata", r_a_rdata, 0);
    check("mrst_in_b_rdata", r_b_rdata, 0);
    check("mrst_in_rom_addr", r_rom_addr, 0);
    #1 RSTb = 1'b1;
    tick();
    #1;
    check("mrst_b_rvalid", r_b_rvalid, 0);
    check("mrst_a_rvalid", r_a_rvalid, 0);
    check("mrst_rom_addr_after", r_rom_addr, 0);
    tick();
    A_REQ = 1'b1; A_ADDR = 8'h10;
    B_REQ = 1'b1; B_ADDR = 8'h20;
    #1;
    check("mrst_cont_a_gnt", r_a_gnt, 1);
    check("mrst_cont_b_gnt", r_b_gnt, 0);

    // Idle address hold
    tick();
    B_REQ = 1'b0;
    A_REQ = 1'b1; A_ADDR = 8'h7F;
    #1;
    check("idle_grant_addr", r_rom_addr, 8'h7F);
    for (int c = 1; c <= 10; c++) begin
      tick();
      A_REQ = 1'b0;
      A_ADDR = 8'h00;
      #1;
      check("idle_rom_addr", r_rom_addr, 8'h7F);
      check("idle_a_rvalid", r_a_rvalid, (c == 1));
      check("idle_b_rvalid", r_b_rvalid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Two-requester arbiter sharing one single-port, synchronous-read ROM (1-cycle registered read, 16-bit words, 8-bit address).
- Port A is normally CPU instruction fetch; port B is a data/loader requester.
- Per cycle: grants at most one request, drives the ROM address, and steers the returned word to the owning port one cycle later.
- Sits between the requesters and the ROM instance; the ROM itself is unchanged.

Parameters:
- BITS, 16, ROM data width.
- ADDRESS_BITS, 8, ROM address width.
- PRIORITY_MODE, 0, 0 = round-robin between A and B; 1 = fixed priority, A always wins.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RSTb  in  1  asynchronous active-low reset.
- A_REQ  in  1  port A read request; held until A_GNT.
- A_ADDR  in  ADDRESS_BITS  port A word address; stable while A_REQ high.
- A_GNT  out  1  port A request accepted this cycle (combinational).
- A_RVALID  out  1  A_RDATA valid this cycle.
- A_RDATA  out  BITS  port A read data.
- B_REQ, B_ADDR, B_GNT, B_RVALID, B_RDATA  same as port A, for port B.
- ROM_ADDRESS  out  ADDRESS_BITS  to ROM ADDRESS.
- ROM_DATA  in  BITS  from ROM DATA_OUT.

Behaviour:
- Reset values:
  - A_GNT = B_GNT = 0, A_RVALID = B_RVALID = 0, A_RDATA = B_RDATA = 0, ROM_ADDRESS = 0.
  - last_grant = B, so A wins the first contention.
  - Pending-owner register = NONE.
- Grant, cycle N, combinational:
  - Only A_REQ: A_GNT = 1.
  - Only B_REQ: B_GNT = 1.
  - Both, PRIORITY_MODE = 0: grant the port that is not last_grant.
  - Both, PRIORITY_MODE = 1: grant A.
  - Neither: no grant.
  - A_GNT and B_GNT are never high together.
- Address:
  - ROM_ADDRESS = granted port's ADDR in cycle N.
  - With no grant, ROM_ADDRESS holds the last granted address (held register), so the ROM input never toggles while idle.
- Ownership tracking:
  - On a grant, owner register <= granted port at the rising edge ending cycle N; otherwise owner <= NONE.
  - last_grant updates only on a grant.
- Return path, cycle N+1:
  - owner == A: A_RVALID = 1, A_RDATA = ROM_DATA.
  - owner == B: same on the B side.
  - Latency: request accepted in cycle N, data in N+1.
  - Throughput: one read per cycle, back-to-back across or within ports.
- Data hold:
  - Each port's RDATA holds its last delivered word, from a per-port register loaded when its RVALID is high, until that port's next RVALID.
  - The other port's RDATA is unaffected.
- Fairness:
  - In round-robin mode, with both requesting every cycle, grants alternate A, B, A, B.
  - A continuously requesting port waits at most 1 cycle.
  - In fixed mode B can starve; this is intended.
- Request dropped before grant: legal; no grant, no RVALID.
- A request with GNT high is consumed. Keeping REQ high the next cycle is a new request (same or new address).
- Reset mid-operation:
  - Owner register is cleared, so no RVALID is produced for a read granted in the cycle before reset.
  - RDATA hold registers clear to 0.
  - last_grant returns to B.
- Address width: no arithmetic. All ADDRESS_BITS values map directly; no wrap or range checks.

Decomposition:
- Shared package: owner encoding constants OWNER_NONE = 2'b00, OWNER_A = 2'b01, OWNER_B = 2'b10, and PRIORITY_MODE encodings PRIO_RR = 0, PRIO_FIXED_A = 1.
- One natural sub-module: rom_arb_rr2. It is the 2-way grant logic plus last_grant register (inputs: two requests, mode; outputs: one-hot grant).
- Return-path demux and hold registers stay in rom_arbiter.

Test Plan:
- Bench ROM model: mem[i] = {i[7:0], ~i[7:0]}.
- A-only read:
  - Stimulus: A_REQ = 1, A_ADDR = 8'h03 in cycle N.
  - Required: A_GNT = 1 in N; A_RVALID = 1 and A_RDATA = 16'h03FC in N+1; B_RVALID stays 0.
- Simultaneous contention, round-robin:
  - Stimulus: after reset, A and B request every cycle, A_ADDR = 8'h10, B_ADDR = 8'h20.
  - Required: grants A, B, A, B. RVALIDs follow one cycle later. A_RDATA = 16'h10EF, B_RDATA = 16'h20DF.
- Fixed priority, PRIORITY_MODE = 1:
  - Stimulus: same stimulus as the contention test.
  - Required: A_GNT = 1 every cycle; B_GNT never asserts. Then drop A_REQ: B granted the same cycle, B_RDATA = 16'h20DF next cycle.
- Data hold:
  - Stimulus: A reads 8'h05, then idles for 5 cycles while B reads 8'h06 twice.
  - Required: A_RDATA remains 16'h05FA throughout; B_RDATA = 16'h06F9.
- Reset mid-operation:
  - Stimulus: grant B at 8'h40 in cycle N, then pulse RSTb low asynchronously mid-cycle N.
  - Required: no B_RVALID in N+1. Outputs and ROM_ADDRESS = 0. The next contention is won by A.
- Idle address hold:
  - Stimulus: grant A at 8'h7F, then 10 idle cycles.
  - Required: ROM_ADDRESS = 8'h7F constant throughout; no RVALID after N+1.
